// File: rtl/minicpu_pkg.sv
// Shared constants for the minicpu memory path: port identifiers and default bus widths.
package minicpu_pkg;

  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/sram_port_arbiter_pick2.sv
// Combinational 2-way picker for sram_port_arbiter; round-robin when ARB_ROUND_ROBIN_EN
// is defined, otherwise fixed priority with DATA winning every contended cycle.
module arb_pick2
  import minicpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    gnt = 2'b00;
    if (req[PORT_DATA] && req[PORT_INST]) begin
      // Hand the contended slot to whichever port did not win last time.
      if (last == PORT_INST) gnt[PORT_DATA] = 1'b1;
      else                   gnt[PORT_INST] = 1'b1;
    end else begin
      gnt = req;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    gnt = 2'b00;
    if (req[PORT_DATA])      gnt[PORT_DATA] = 1'b1;
    else if (req[PORT_INST]) gnt[PORT_INST] = 1'b1;
  end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between fetch and load/store with a 1-cycle data phase.
// ARB_ROUND_ROBIN_EN selects round-robin contention; undefined gives DATA fixed priority.
module sram_port_arbiter
  import minicpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       last_grant;
  logic       resp_valid_p1;
  logic       resp_owner_p1;

  // Requests are masked while in reset so every output reads 0 regardless of requesters.
  always_comb begin
    req            = 2'b00;
    req[PORT_INST] = inst_req & resetn;
    req[PORT_DATA] = data_req & resetn;
  end

  arb_pick2 u_pick (
    .req  (req),
    .last (last_grant),
    .gnt  (gnt)
  );

  // ---- Address phase (p0): grant and SRAM mux ----
  assign inst_addr_ok = gnt[PORT_INST];
  assign data_addr_ok = gnt[PORT_DATA];

  always_comb begin
    sram_en    = |gnt;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (gnt[PORT_DATA]) begin
      sram_we    = data_we;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (gnt[PORT_INST]) begin
      sram_addr  = inst_addr;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    last_grant <= PORT_INST;
    else if (|gnt)  last_grant <= gnt[PORT_DATA] ? PORT_DATA : PORT_INST;
  end
`else
  assign last_grant = PORT_INST;
`endif

  // ---- Data phase (p1): response ownership and demux ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid_p1 <= 1'b0;
      resp_owner_p1 <= PORT_INST;
    end else begin
      resp_valid_p1 <= |gnt;
      resp_owner_p1 <= gnt[PORT_DATA] ? PORT_DATA : PORT_INST;
    end
  end

  assign inst_data_ok = resp_valid_p1 && (resp_owner_p1 == PORT_INST);
  assign data_data_ok = resp_valid_p1 && (resp_owner_p1 == PORT_DATA);
  assign inst_rdata   = inst_data_ok ? sram_rdata : '0;
  assign data_rdata   = data_data_ok ? sram_rdata : '0;

endmodule
